// File: rtl/seq_divider_32.sv
// seq_divider_32: multi-cycle restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement truncating division.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic             zero_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] dvd_in;
  logic [WIDTH-1:0] dsr_in;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             last;

`ifdef SIGNED_DIV_EN
  logic neg_q;
  logic neg_r;
`endif

  // One restoring step: shift left, trial-subtract, keep or restore.
  always_comb begin
    shifted = {rem_r, dvd_r[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_r};
    q_bit   = ~diff[WIDTH];
    rem_nxt = q_bit ? diff[WIDTH-1:0]
                    : shifted[WIDTH-1:0];
    dvd_nxt = {dvd_r[WIDTH-2:0], q_bit};
    last    = (cnt == 6'(WIDTH - 1));
  end

  // Operand conditioning on accept and result fix-up on the final step.
  always_comb begin
`ifdef SIGNED_DIV_EN
    if (divisor == '0)
      dvd_in = dividend;
    else if (dividend[WIDTH-1])
      dvd_in = -dividend;
    else
      dvd_in = dividend;
    dsr_in = divisor[WIDTH-1] ? -divisor : divisor;
    q_fin  = neg_q ? -dvd_nxt : dvd_nxt;
    r_fin  = neg_r ? -rem_nxt : rem_nxt;
`else
    dvd_in = dividend;
    dsr_in = divisor;
    q_fin  = dvd_nxt;
    r_fin  = rem_nxt;
`endif
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      dvd_r       <= '0;
      dsr_r       <= '0;
      zero_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
`ifdef SIGNED_DIV_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dvd_r  <= dvd_in;
            dsr_r  <= dsr_in;
            rem_r  <= '0;
            cnt    <= '0;
            zero_r <= (divisor == '0);
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SIGNED_DIV_EN
            neg_q  <= dividend[WIDTH-1]
                    ^ divisor[WIDTH-1];
            neg_r  <= dividend[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (zero_r) begin
            quotient    <= '1;
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            rem_r <= rem_nxt;
            dvd_r <= dvd_nxt;
            cnt   <= cnt + 6'd1;
            if (last) begin
              quotient  <= q_fin;
              remainder <= r_fin;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
